// File: rtl/aes_dec_key_sched.sv
// ---------------------------------------------------------------------------
// aes_dec_key_sched
// AES-128 key schedule for a decryption datapath. A cipher key is expanded
// into eleven round keys, one per cycle, held in an 11x128 register array.
// The round keys are then streamed out last-first (rk[10] down to rk[0]),
// one per consumer request.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   key_valid_in  cipher key presented on key_in
//   key_in        cipher key, [127:96] is w0 (byte 0 at the MSB)
//   key_ready     block can accept a key
//   rk_req        consumer takes the current round key
//   rk_valid      round_key / rk_index are valid
//   round_key     current round key (0 when rk_valid is low)
//   rk_index      index of round_key, 10 down to 0 (0 when rk_valid is low)
//   done          one-cycle pulse after round key 0 is taken
//   busy          expanding or streaming
//   replay        (AES_KEY_REPLAY_EN only) restream the stored schedule
//
// Build option
//   AES_KEY_REPLAY_EN : adds the replay port and a schedule-valid flag so a
//                       previously expanded schedule can be streamed again.
// ---------------------------------------------------------------------------
// state     | meaning
// ST_IDLE   | waiting for a key (or a replay request)
// ST_EXPAND | computing rk[cnt] from rk[cnt-1], cnt = 1..10
// ST_STREAM | presenting rk[cnt] to the consumer, cnt = 10..0
// ---------------------------------------------------------------------------
module aes_dec_key_sched #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_ready,
    input  logic              rk_req,
    output logic              rk_valid,
    output logic [DATA_W-1:0] round_key,
    output logic [3:0]        rk_index,
    output logic              done,
`ifdef AES_KEY_REPLAY_EN
    output logic              busy,
    input  logic              replay
`else
    output logic              busy
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_STREAM} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits at the MSB, so entry x starts at bit 8*(255-x) = {~x,3'b0}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX[base +: 8];
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rk_q [0:10];
`ifdef AES_KEY_REPLAY_EN
    logic              sched_vld_q, sched_vld_d;
`endif

    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] prev_rk, next_rk;
    logic [31:0]       w0, w1, w2, w3, rot_w, temp_w, n0, n1, n2, n3;
    logic [7:0]        rcon;

    always_comb begin
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // One full round of key expansion: rk[cnt] from rk[cnt-1].
    always_comb begin
        prev_rk = rk_q[cnt_q - 4'd1];
        {w0, w1, w2, w3} = prev_rk;
        rot_w  = {w3[23:0], w3[31:24]};
        temp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])} ^ {rcon, 24'h000000};
        n0 = w0 ^ temp_w;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = next_rk;
`ifdef AES_KEY_REPLAY_EN
        sched_vld_d = sched_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // No capture in the done cycle: key_ready rises one cycle later.
                if (key_valid_in && !done_q) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_data = key_in;
                    cnt_d   = 4'd1;
                    state_d = ST_EXPAND;
`ifdef AES_KEY_REPLAY_EN
                    sched_vld_d = 1'b0;
                end else if (replay && sched_vld_q && !done_q) begin
                    cnt_d   = 4'd10;
                    state_d = ST_STREAM;
`endif
                end
            end
            ST_EXPAND: begin
                wr_en = 1'b1;
                if (cnt_q == 4'd10) begin
                    state_d = ST_STREAM;
`ifdef AES_KEY_REPLAY_EN
                    sched_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STREAM: begin
                if (rk_req) begin
                    if (cnt_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
`ifdef AES_KEY_REPLAY_EN
            sched_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef AES_KEY_REPLAY_EN
            sched_vld_q <= sched_vld_d;
`endif
        end
    end

    // Key storage is not reset; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rk_q[wr_idx] <= wr_data;
        end
    end

    assign key_ready = (state_q == ST_IDLE) && !done_q;
    assign rk_valid  = (state_q == ST_STREAM);
    assign round_key = rk_valid ? rk_q[cnt_q] : '0;
    assign rk_index  = rk_valid ? cnt_q : 4'd0;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
`timescale 1ns/1ps
module tb_aes_dec_key_sched;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_INJ = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_req;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_index;
    logic         done;
    logic         busy;
`ifdef AES_KEY_REPLAY_EN
    logic         replay;
`endif

    always #5 clk = ~clk;

    aes_dec_key_sched #(.DATA_W(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid_in (key_valid_in),
        .key_in       (key_in),
        .key_ready    (key_ready),
        .rk_req       (rk_req),
        .rk_valid     (rk_valid),
        .round_key    (round_key),
        .rk_index     (rk_index),
        .done         (done),
`ifdef AES_KEY_REPLAY_EN
        .busy         (busy),
        .replay       (replay)
`else
        .busy         (busy)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;
    exp_t sb[$];

    logic [7:0]   sbox_m [256];
    logic [127:0] mdl_rk [11];

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
        logic [15:0] d;
        d = {b, b} << s;
        return d[15:8];
    endfunction

    // S-box from its mathematical definition: GF(2^8) inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_schedule();
        for (int i = 10; i >= 0; i--) sb.push_back(exp_t'({4'(i), mdl_rk[i]}));
    endtask

    // Monitor: every take is compared against the head of the scoreboard.
    logic done_exp = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            done_exp = 1'b0;
        end else begin
            if (done || done_exp) chk("done_pulse", done, done_exp);
            if (!rk_valid) chk("round_key_zero_when_invalid", round_key, 0);
            done_exp = 1'b0;
            if (rk_valid && rk_req) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_take: index %0d key %h, nothing expected", rk_index, round_key);
                end else begin
                    e = sb.pop_front();
                    chk("stream_key", {rk_index, round_key}, {e.idx, e.key});
                    done_exp = (e.idx == 4'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [127:0] k);
        int n = 0;
        while (!key_ready && n < 50) begin tick(); n++; end
        chk("key_ready_before_send", key_ready, 1);
        key_in = k;
        key_valid_in = 1'b1;
        expand_model(k);
        push_schedule();
        tick();
        key_valid_in = 1'b0;
    endtask

    // Called right after the capture edge; counts edges until rk_valid.
    task automatic wait_valid(input int inject_at, input bit noise);
        int n = 1;
        while (!rk_valid && n < 30) begin
            key_valid_in = (n == inject_at) || (noise && ($urandom_range(0, 1) == 1));
            if (noise) rk_req = ($urandom_range(0, 1) == 1);
            if (n == inject_at) begin
                key_in = KEY_INJ;
                chk("key_ready_low_in_expand", {key_ready, busy}, 2'b01);
            end else if (key_valid_in) begin
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            n++;
        end
        key_valid_in = 1'b0;
        chk("latency_to_rk_valid", n, 11);
    endtask

    task automatic stream(input int mode);
        int n = 0;
        bit hit = 0;
        bit stop = 0;
        bit ok;
        while (!stop && n < 300) begin
            if (!hit && rk_valid && mode == 1 && rk_index == 4'd7) begin
                hit = 1;
                rk_req = 1'b0;
                ok = 1;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    if (!(rk_valid && rk_index == 4'd7 && round_key === mdl_rk[7])) ok = 0;
                end
                chk("stall_stable_at_7", ok, 1);
                rk_req = 1'b1;
                tick();
                chk("stall_release_to_6", {rk_index, round_key}, {4'd6, mdl_rk[6]});
            end else if (!hit && rk_valid && mode == 2 && rk_index == 4'd0) begin
                hit = 1;
                rk_req = 1'b1;
                key_valid_in = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
                tick();
                chk("collide_done_cycle", {done, key_ready, rk_valid}, 3'b100);
                rk_req = 1'b0;
                tick();
                chk("collide_ready_after_done", {key_ready, busy}, 2'b10);
                key_valid_in = 1'b0;
                tick();
                chk("collide_key_not_captured", {busy, rk_valid}, 2'b00);
                stop = 1;
            end else if (!hit && rk_valid && mode == 3 && rk_index == 4'd5) begin
                hit = 1;
                #1 reset = 1'b1;
                #1 chk("async_reset_mid_stream", {key_ready, rk_valid, busy, done, rk_index, round_key},
                       {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 128'd0});
                sb.delete();
                rk_req = 1'b0;
                tick();
                reset = 1'b0;
                stop = 1;
            end else begin
                rk_req = ($urandom_range(0, 3) != 0);
                tick();
                n++;
                if (done) stop = 1;
            end
        end
        rk_req = 1'b0;
        if (n >= 300) begin
            n_checks++;
            $display("FAIL stream_timeout: mode %0d never finished", mode);
        end
        if (mode != 0 && !hit) begin
            n_checks++;
            $display("FAIL stream_point_missed: mode %0d target index never reached", mode);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        reset = 1'b1;
        key_valid_in = 1'b0;
        key_in = '0;
        rk_req = 1'b0;
`ifdef AES_KEY_REPLAY_EN
        replay = 1'b0;
`endif
        build_sbox();
        #2;
        chk("reset_state", {key_ready, rk_valid, busy, done, rk_index, round_key},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 128'd0});
        tick();
        reset = 1'b0;
        tick();

        // FIPS-197 key, consumer always requesting
        rk_req = 1'b1;
        send_key(KEY_A);
        wait_valid(0, 0);
        chk("first_round_key", {rk_valid, rk_index, round_key}, {1'b1, 4'd10, RK10_A});
        n = 0;
        while (rk_valid && rk_index != 4'd0 && n < 20) begin
            if (rk_index == 4'd1) chk("round_key_1", round_key, RK1_A);
            tick();
            n++;
        end
        chk("round_key_0_is_key", {rk_valid, rk_index, round_key}, {1'b1, 4'd0, KEY_A});
        tick();
        chk("done_after_final_take", {done, rk_valid, key_ready}, 3'b100);
        rk_req = 1'b0;

`ifdef AES_KEY_REPLAY_EN
        tick();
        replay = 1'b1;
        push_schedule();
        tick();
        replay = 1'b0;
        chk("replay_first_key", {rk_valid, rk_index, round_key}, {1'b1, 4'd10, RK10_A});
        stream(0);
`endif

        // All-zero key with a stall at index 7
        send_key(128'd0);
        wait_valid(0, 0);
        chk("zero_key_rk10", round_key, RK10_Z);
        stream(1);

        // Key injected during expansion, then take/key collision at index 0
        send_key({$urandom, $urandom, $urandom, $urandom});
        wait_valid(4, 0);
        stream(2);

        // Reset in the middle of streaming
        send_key({$urandom, $urandom, $urandom, $urandom});
        wait_valid(0, 0);
        stream(3);
`ifdef AES_KEY_REPLAY_EN
        replay = 1'b1;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rk_valid || busy) ok = 0;
        end
        replay = 1'b0;
        chk("replay_ignored_after_reset", ok, 1);
`endif

        // Random keys with random request and key noise
        for (int k = 0; k < 6; k++) begin
            send_key({$urandom, $urandom, $urandom, $urandom});
            wait_valid(0, 1);
            stream(0);
        end

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_dec_key_sched.md
AES_DEC_KEY_SCHED -- requirements
Module: aes_dec_key_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 128, giving the key and round-key width; only 128 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port key_valid_in, input, 1 bit: cipher key presented.
REQ-005 SHALL have port key_in, input, DATA_W bits: cipher key; [127:96] is w0, FIPS-197 byte order with byte 0 at the MSB.
REQ-006 SHALL have port key_ready, output, 1 bit: block can accept a key.
REQ-007 SHALL have port rk_req, input, 1 bit: consumer takes the current round key.
REQ-008 SHALL have port rk_valid, output, 1 bit: round_key and rk_index are valid.
REQ-009 SHALL have port round_key, output, DATA_W bits: round key feeding the decryption round stage.
REQ-010 SHALL have port rk_index, output, 4 bits: index of the round key on round_key, 10 down to 0.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after round key 0 is taken.
REQ-012 SHALL have port busy, output, 1 bit: high in EXPAND or STREAM.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND and STREAM.
REQ-014 IDLE: key_ready=1; on key_valid_in=1 SHALL store key_in as rk[0], clear the counter to 1, and go to EXPAND.
REQ-015 EXPAND: SHALL compute one round key per cycle: rk[i] = f(rk[i-1], Rcon[i]), using RotWord, SubWord via four forward S-box lookups, and XOR chaining w[4i+j] = w[4i+j-4] ^ temp.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 in the MSB byte.
REQ-017 After rk[10] is written (10 EXPAND cycles), SHALL go to STREAM with the index at 10.
REQ-018 Latency: with the key accepted at cycle 0, rk_valid SHALL first be 1 at cycle 11.
REQ-019 STREAM: rk_valid=1, round_key=rk[rk_index], rk_index starts at 10.
REQ-020 STREAM: rk_req=1 SHALL decrement rk_index on the next edge; round_key SHALL hold stable while rk_req=0.
REQ-021 STREAM: rk_req=1 at rk_index=0 SHALL pulse done for exactly 1 cycle, drop rk_valid, and return to IDLE on the same edge.
REQ-022 Storage SHALL be an 11x128 register array; the index SHALL never wrap below 0.
REQ-023 key_valid_in in EXPAND or STREAM SHALL be ignored (key_ready=0); no new key is captured and streaming is not disturbed.
REQ-024 rk_req while rk_valid=0 SHALL be ignored.
REQ-025 When rk_req=1 and key_valid_in=1 arrive in the same cycle at index 0, the key SHALL NOT be captured; key_ready first rises the cycle after done.
REQ-026 round_key SHALL be 0 whenever rk_valid=0.

Reset
REQ-027 On reset=1, outputs SHALL be key_ready=1, rk_valid=0, round_key=0, rk_index=0, done=0, busy=0, FSM=IDLE, immediately and independently of clk.
REQ-028 Reset mid-EXPAND or mid-STREAM SHALL abort the operation and invalidate the stored keys; the key array contents need not be cleared.
REQ-029 First capture after deassertion SHALL occur no earlier than the first rising edge with reset=0.

Configuration
REQ-030 With macro AES_KEY_REPLAY_EN defined: SHALL add input port replay (1 bit).
REQ-031 With AES_KEY_REPLAY_EN: replay=1 in IDLE with a valid stored schedule SHALL go to STREAM at index 10 next cycle, with no re-expansion.
REQ-032 With AES_KEY_REPLAY_EN: if key_valid_in and replay are both 1, key_valid_in SHALL win.
REQ-033 With AES_KEY_REPLAY_EN: the schedule-valid flag SHALL be cleared by reset and set on entry to STREAM from EXPAND; replay with the flag clear SHALL be ignored.
REQ-034 Without AES_KEY_REPLAY_EN: the replay port SHALL be absent and each streaming pass SHALL require a new key.

Verification
REQ-035 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_req held 1 -> cycle 11: rk_index=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_index=1 gives a0fafe1788542cb123a339392a6c7605; rk_index=0 gives the key itself; done at the final take.
REQ-036 rk_req held 0 for 5 cycles in STREAM at index 7 -> round_key and rk_index stable; then 1 -> index 6 next cycle.
REQ-037 key_valid_in=1 with key 000102030405060708090a0b0c0d0e0f during EXPAND cycle 4 -> ignored; streamed keys match the first key.
REQ-038 reset=1 pulsed at STREAM index 5 -> rk_valid=0 and key_ready=1 without a clock edge; replay (if AES_KEY_REPLAY_EN) ignored afterwards.
REQ-039 AES_KEY_REPLAY_EN defined, replay=1 one cycle after done -> rk_valid next cycle with rk_index=10 and round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-040 Key all zeros -> rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
